video_timing_generator: RTL and testbench

- Parametrised raster timing generator that drives a VGA-class monitor and feeds pixel-position data to the downstream pixel/colour pipeline.
- Widths, porch/sync lengths and sync polarities are parametrised.
- A pixel clock-enable lets it run from a faster system clock.
- A run/stop control halts cleanly at a frame boundary.
- Frame/line strobes and a frame counter are provided for pipeline sequencing.

---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/video_timing_generator_counter.sv | 36 +++
 rtl/video_timing_generator.sv | 126 ++++++++++++
 tb/tb_video_timing_generator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and VGA 640x480@60 defaults for the raster timing generator.
// Helper functions derive line/frame totals and sync window bounds.
package video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    function automatic int timing_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int sync_first(input int disp, input int front);
        return disp + front;
    endfunction

    function automatic int sync_last(input int disp, input int front, input int sync);
        return disp + front + sync - 1;
    endfunction

endpackage

// File: rtl/video_timing_generator_counter.sv
// Wrapping position counter: advances on en, wraps to 0 after MAX; count_next is the
// value the register takes on the coming edge. No backpressure; en is the only gate.
module timing_counter #(
    parameter int W   = 11,
    parameter int MAX = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         at_max,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    assign at_max = (count == MAX_W);
    assign wrap   = en && at_max;

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = at_max ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator with run/stop at frame boundaries; all outputs registered and
// aligned with hpos/vpos. No backpressure: ce paces the raster, ce=0 freezes it.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int HW         = 11,
    parameter int VW         = 10,
    parameter int H_DISPLAY  = VGA_H_DISPLAY,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_DISPLAY  = VGA_V_DISPLAY,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          run,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic          active,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [HW-1:0] H_ACT      = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_FIRST   = HW'(sync_first(H_DISPLAY, H_FRONT));
    localparam logic [HW-1:0] HS_LAST    = HW'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [VW-1:0] V_ACT      = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VS_FIRST   = VW'(sync_first(V_DISPLAY, V_FRONT));
    localparam logic [VW-1:0] VS_LAST    = VW'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));

    state_t          state;
    state_t          state_n;
    logic            cnt_en;
    logic [HW-1:0]   h_next;
    logic [VW-1:0]   v_next;
    logic            h_max;
    logic            v_max;
    logic            h_wrap;
    logic            v_wrap;
    logic            eof;
    logic            live_n;

    assign cnt_en = ce && (state != IDLE);
    assign eof    = h_max && v_max;
    assign live_n = (state_n != IDLE);

    timing_counter #(.W(HW), .MAX(H_TOTAL - 1)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (cnt_en),
        .count      (hpos),
        .count_next (h_next),
        .at_max     (h_max),
        .wrap       (h_wrap)
    );

    timing_counter #(.W(VW), .MAX(V_TOTAL - 1)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (vpos),
        .count_next (v_next),
        .at_max     (v_max),
        .wrap       (v_wrap)
    );

    // The state before the edge decides end-of-frame: STOPPING always retires to IDLE.
    always_comb begin
        state_n = state;
        if (ce) begin
            case (state)
                IDLE:     if (run) state_n = RUN;
                RUN:      state_n = run ? RUN : STOPPING;
                STOPPING: begin
                    if (eof)      state_n = IDLE;
                    else if (run) state_n = RUN;
                end
                default:  state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            active      <= 1'b0;
            frame_count <= '0;
        end else begin
            state  <= state_n;
            active <= live_n;
            if (ce) begin
                hsync       <= (live_n && h_next >= HS_FIRST && h_next <= HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
                vsync       <= (live_n && v_next >= VS_FIRST && v_next <= VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
                display_on  <= live_n && (h_next < H_ACT) && (v_next < V_ACT);
                line_start  <= live_n && (h_next == '0);
                frame_start <= live_n && (h_next == '0) && (v_next == '0);
                if (v_wrap) begin
                    frame_count <= frame_count + 1'b1;
                end
            end else begin
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for the raster timing generator on a reduced 16x8 raster with positive syncs.
module tb_video_timing_generator;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;

    typedef struct packed {
        logic [10:0] hpos;
        logic [9:0]  vpos;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic        act;
        logic [7:0]  fc;
    } exp_t;

    typedef struct {
        logic ce;
        logic run;
        exp_t e;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        run;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic        line_start;
    logic        frame_start;
    logic        active;
    logic [7:0]  frame_count;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t cur;
    vec_t tbl[20];

    int         m_st;
    int         m_h;
    int         m_v;
    logic [7:0] m_fc;
    logic       m_ls;
    logic       m_fs;

    video_timing_generator #(
        .HW(11), .VW(10),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FW(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .run         (run),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .active      (active),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ex(input int h, input int v, input bit hs, input bit vs,
                                input bit de, input bit ls, input bit fs, input bit act);
        exp_t e;
        e.hpos = 11'(h); e.vpos = 10'(v);
        e.hs = hs; e.vs = vs; e.de = de; e.ls = ls; e.fs = fs; e.act = act;
        e.fc = 8'd0;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t e;
        e.hpos = hpos; e.vpos = vpos; e.hs = hsync; e.vs = vsync; e.de = display_on;
        e.ls = line_start; e.fs = frame_start; e.act = active; e.fc = frame_count;
        return e;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_h = 0; m_v = 0; m_fc = 8'd0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    // Reference raster: written directly from the frame/line rules.
    task automatic model_step(input logic c, input logic r);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (c) begin
            if (m_st == S_IDLE) begin
                if (r) begin
                    m_st = S_RUN; m_ls = 1'b1; m_fs = 1'b1;
                end
            end else if (m_h == HT - 1 && m_v == VT - 1) begin
                m_fc = m_fc + 8'd1;
                m_h = 0; m_v = 0;
                if (m_st == S_STOP) m_st = S_IDLE;
                else begin
                    m_st = r ? S_RUN : S_STOP; m_ls = 1'b1; m_fs = 1'b1;
                end
            end else begin
                if (m_h == HT - 1) begin
                    m_h = 0; m_v = m_v + 1; m_ls = 1'b1;
                end else begin
                    m_h = m_h + 1;
                end
                if (m_st == S_RUN && !r) m_st = S_STOP;
                else if (m_st == S_STOP && r) m_st = S_RUN;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   live;
        live   = (m_st != S_IDLE);
        e.hpos = 11'(m_h);
        e.vpos = 10'(m_v);
        e.hs   = live && m_h >= 10 && m_h <= 12;
        e.vs   = live && m_v >= 5 && m_v <= 6;
        e.de   = live && m_h < 8 && m_v < 4;
        e.ls   = m_ls;
        e.fs   = m_fs;
        e.act  = live;
        e.fc   = m_fc;
        return e;
    endfunction

    // Called at a negedge: drive, let one posedge happen, compare at the next negedge.
    task automatic step(input logic c, input logic r, input bit use_tbl, input exp_t tv);
        exp_t e;
        ce  = c;
        run = r;
        @(posedge clk);
        model_step(c, r);
        sb_q.push_back(use_tbl ? tv : model_out());
        @(negedge clk);
        cur = dut_out();
        e   = sb_q.pop_front();
        chk(use_tbl ? "vector" : "model", 64'(cur), 64'(e));
    endtask

    task automatic mstep(input logic c, input logic r);
        step(c, r, 1'b0, '0);
    endtask

    initial begin
        int   t0;
        int   t1;
        int   n;
        int   bad;
        bit   found;
        logic [7:0] fc_before;

        tbl[0]  = '{1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, ex(0, 0, 0, 0, 1, 1, 1, 1)};
        tbl[2]  = '{1'b0, 1'b1, ex(0, 0, 0, 0, 1, 0, 0, 1)};
        for (int i = 3; i <= 9; i++) tbl[i] = '{1'b1, 1'b1, ex(i - 2, 0, 0, 0, 1, 0, 0, 1)};
        tbl[10] = '{1'b1, 1'b1, ex(8, 0, 0, 0, 0, 0, 0, 1)};
        tbl[11] = '{1'b1, 1'b1, ex(9, 0, 0, 0, 0, 0, 0, 1)};
        tbl[12] = '{1'b1, 1'b1, ex(10, 0, 1, 0, 0, 0, 0, 1)};
        tbl[13] = '{1'b0, 1'b1, ex(10, 0, 1, 0, 0, 0, 0, 1)};
        tbl[14] = '{1'b1, 1'b1, ex(11, 0, 1, 0, 0, 0, 0, 1)};
        tbl[15] = '{1'b1, 1'b1, ex(12, 0, 1, 0, 0, 0, 0, 1)};
        tbl[16] = '{1'b1, 1'b1, ex(13, 0, 0, 0, 0, 0, 0, 1)};
        tbl[17] = '{1'b1, 1'b1, ex(14, 0, 0, 0, 0, 0, 0, 1)};
        tbl[18] = '{1'b1, 1'b1, ex(15, 0, 0, 0, 0, 0, 0, 1)};
        tbl[19] = '{1'b1, 1'b1, ex(0, 1, 0, 0, 1, 1, 0, 1)};

        reset = 1'b0; ce = 1'b0; run = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(dut_out()), 64'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
        reset = 1'b1;

        for (int i = 0; i < 20; i++) step(tbl[i].ce, tbl[i].run, 1'b1, tbl[i].e);

        // Line strobe period at ce=1.
        t0 = -1; t1 = -1;
        for (int i = 0; i < 60 && t1 < 0; i++) begin
            mstep(1'b1, 1'b1);
            if (cur.ls) begin
                if (t0 < 0) t0 = i; else t1 = i;
            end
        end
        chk("line_period", 64'(t1 - t0), 64'd16);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b1);
            found = cur.fs;
        end
        chk("first_frame_seen", 64'(found), 64'd1);
        chk("frame_count_1", 64'(cur.fc), 64'd1);

        // ce one edge in three: frame takes 384 clk, no strobes on ce=0 edges.
        t0 = -1; t1 = -1; bad = 0;
        for (int i = 0; i < 1000 && t1 < 0; i++) begin
            mstep((i % 3) == 0, 1'b1);
            if ((i % 3) != 0 && (cur.ls || cur.fs)) bad++;
            if (cur.fs) begin
                if (t0 < 0) t0 = i; else t1 = i;
            end
        end
        chk("ce_frame_period", 64'(t1 - t0), 64'd384);
        chk("ce_idle_strobes", 64'(bad), 64'd0);

        // Drop run mid-frame at (3,2).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b1);
            found = (cur.hpos == 11'd3 && cur.vpos == 10'd2);
        end
        chk("reach_3_2", 64'(found), 64'd1);
        fc_before = m_fc;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b0);
            found = !cur.act;
        end
        chk("stop_reaches_idle", 64'(found), 64'd1);
        chk("stop_fc_inc", 64'(cur.fc), 64'(fc_before + 8'd1));
        chk("stop_idle_out", 64'({cur.hpos, cur.vpos, cur.de, cur.hs, cur.vs}), 64'd0);

        // Drop run exactly on the end-of-frame edge: one more complete frame.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b1);
            found = (cur.hpos == 11'd15 && cur.vpos == 10'd7);
        end
        chk("reach_eof", 64'(found), 64'd1);
        mstep(1'b1, 1'b0);
        chk("eof_drop_frame_start", 64'(cur.fs), 64'd1);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            mstep(1'b1, 1'b0);
            n++;
            found = !cur.act;
        end
        chk("extra_frame_len", 64'(n), 64'd128);

        // Re-assert run while stopping: raster carries on through the frame boundary.
        mstep(1'b1, 1'b1);
        repeat (20) mstep(1'b1, 1'b1);
        repeat (5) mstep(1'b1, 1'b0);
        bad = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b1);
            if (!cur.act) bad++;
            found = cur.fs;
        end
        chk("resume_frame_start", 64'(found), 64'd1);
        chk("resume_no_idle", 64'(bad), 64'd0);

        // Asynchronous reset mid-line at (5,1).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            mstep(1'b1, 1'b1);
            found = (cur.hpos == 11'd5 && cur.vpos == 10'd1);
        end
        chk("reach_5_1", 64'(found), 64'd1);
        #2 reset = 1'b0;
        #1 chk("async_reset", 64'(dut_out()), 64'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        mstep(1'b1, 1'b1);
        chk("restart_frame_start", 64'({cur.hpos, cur.vpos, cur.fs}), 64'd1);

        // Frame counter wraps 255 -> 0.
        found = 1'b0;
        for (int i = 0; i < 34000 && !found; i++) begin
            logic [7:0] prev;
            prev = cur.fc;
            mstep(1'b1, 1'b1);
            found = (prev == 8'd255 && cur.fc == 8'd0);
        end
        chk("fc_wrap", 64'(found), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
